// File: rtl/ship_life_ctl_pkg.sv
// Shared encodings and helpers for the ship life-cycle controller and its frame timing.
package ship_ctl_pkg;

  localparam int FRAME_W = 8;
  localparam int CNT_W   = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ALIVE     = 3'd1,
    ST_DYING     = 3'd2,
    ST_RESPAWN   = 3'd3,
    ST_GAME_OVER = 3'd4
  } state_e;

  // Visible during even-numbered blink half-periods, starting visible at frame 0.
  function automatic logic blink_on(input logic [FRAME_W-1:0] cnt, input int unsigned half);
    return ((32'(cnt) / half) & 32'd1) == 32'd0;
  endfunction

endpackage

// File: rtl/ship_life_ctl_frame_tick_gen.sv
// vsync two-flop synchroniser plus registered rising-edge pulse (one pclk wide).
// Tick appears 3 clocks after the raw vsync edge; reusable by other per-frame controllers.
module frame_tick_gen (
  input  logic clk,
  input  logic rst_n,
  input  logic vsync_in,
  output logic frame_tick
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic tick_q;
  logic tick_d;

  always_comb begin
    tick_d = sync2_q & ~prev_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      sync1_q <= vsync_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      tick_q  <= tick_d;
    end
  end

  assign frame_tick = tick_q;

endmodule

// File: rtl/ship_life_ctl.sv
// Player ship life-cycle FSM: IDLE / ALIVE / DYING / RESPAWN (blinking invulnerable) / GAME_OVER.
// Optional SHIP_EXTRA_LIFE_EN adds an extra_life pulse input that gives back one death.
module ship_life_ctl
  import ship_ctl_pkg::*;
#(
  parameter int unsigned LIVES         = 3,
  parameter int unsigned DEATH_FRAMES  = 60,
  parameter int unsigned INVULN_FRAMES = 120,
  parameter int unsigned BLINK_FRAMES  = 8
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             start,
  input  logic             hit,
  input  logic             vsync_in,
`ifdef SHIP_EXTRA_LIFE_EN
  input  logic             extra_life,
`endif
  output logic             ship_dead,
  output logic             ship_visible,
  output logic             fire_enable,
  output logic             respawn,
  output logic [CNT_W-1:0] dead_count,
  output logic [CNT_W-1:0] lives_left,
  output logic             game_over,
  output logic [2:0]       state_out
);

  localparam logic [CNT_W-1:0] LIVES_C = CNT_W'(LIVES);

  state_e             state_q, state_d;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0]   dead_count_q, dead_count_d;
  logic               start_prev_q;
  logic               ship_dead_q, ship_dead_d;
  logic               ship_visible_q, ship_visible_d;
  logic               fire_enable_q, fire_enable_d;
  logic               respawn_q, respawn_d;
  logic               game_over_q, game_over_d;
  logic               frame_tick_s;
  logic               start_rise_s;
  logic               extra_s;

`ifdef SHIP_EXTRA_LIFE_EN
  assign extra_s = extra_life;
`else
  assign extra_s = 1'b0;
`endif

  frame_tick_gen u_tick (
    .clk        (pclk),
    .rst_n      (rst),
    .vsync_in   (vsync_in),
    .frame_tick (frame_tick_s)
  );

  assign start_rise_s = start & ~start_prev_q;

  // Next state, death count and respawn pulse.
  always_comb begin
    state_d   = state_q;
    respawn_d = 1'b0;
    if (extra_s && (state_q != ST_GAME_OVER) && (dead_count_q != 4'd0)) begin
      dead_count_d = dead_count_q - 4'd1;
    end else begin
      dead_count_d = dead_count_q;
    end
    case (state_q)
      ST_IDLE, ST_GAME_OVER: begin
        if (start_rise_s) begin
          state_d      = ST_RESPAWN;
          dead_count_d = 4'd0;
          respawn_d    = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      ST_ALIVE: begin
        if (hit) begin
          // A coincident extra life cancels the death but the ship still dies.
          dead_count_d = extra_s ? dead_count_q : dead_count_q + 4'd1;
          state_d      = (dead_count_d == LIVES_C) ? ST_GAME_OVER : ST_DYING;
        end else begin
          state_d = ST_ALIVE;
        end
      end
      ST_DYING: begin
        if (32'(frame_cnt_q) >= DEATH_FRAMES) begin
          state_d   = ST_RESPAWN;
          respawn_d = 1'b1;
        end else begin
          state_d = ST_DYING;
        end
      end
      ST_RESPAWN: begin
        if (32'(frame_cnt_q) >= INVULN_FRAMES) begin
          state_d = ST_ALIVE;
        end else begin
          state_d = ST_RESPAWN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Frame counter restarts on every state change and saturates.
  always_comb begin
    if (state_d != state_q) begin
      frame_cnt_d = 8'd0;
    end else if (frame_tick_s && (frame_cnt_q != 8'hFF)) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
    end else begin
      frame_cnt_d = frame_cnt_q;
    end
  end

  // Output decode from the next state so the registered outputs line up with state_q.
  always_comb begin
    ship_dead_d    = 1'b1;
    ship_visible_d = 1'b0;
    fire_enable_d  = 1'b0;
    game_over_d    = 1'b0;
    case (state_d)
      ST_ALIVE: begin
        ship_dead_d    = 1'b0;
        ship_visible_d = 1'b1;
        fire_enable_d  = 1'b1;
      end
      ST_RESPAWN: begin
        ship_dead_d    = 1'b0;
        ship_visible_d = blink_on(frame_cnt_d, BLINK_FRAMES);
        fire_enable_d  = 1'b1;
      end
      ST_GAME_OVER: game_over_d = 1'b1;
      default:      ship_dead_d = 1'b1;
    endcase
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      frame_cnt_q    <= 8'd0;
      dead_count_q   <= 4'd0;
      start_prev_q   <= 1'b0;
      ship_dead_q    <= 1'b1;
      ship_visible_q <= 1'b0;
      fire_enable_q  <= 1'b0;
      respawn_q      <= 1'b0;
      game_over_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      frame_cnt_q    <= frame_cnt_d;
      dead_count_q   <= dead_count_d;
      start_prev_q   <= start;
      ship_dead_q    <= ship_dead_d;
      ship_visible_q <= ship_visible_d;
      fire_enable_q  <= fire_enable_d;
      respawn_q      <= respawn_d;
      game_over_q    <= game_over_d;
    end
  end

  assign ship_dead    = ship_dead_q;
  assign ship_visible = ship_visible_q;
  assign fire_enable  = fire_enable_q;
  assign respawn      = respawn_q;
  assign dead_count   = dead_count_q;
  assign game_over    = game_over_q;
  assign lives_left   = (dead_count_q > LIVES_C) ? 4'd0 : LIVES_C - dead_count_q;
  assign state_out    = state_q;

endmodule

// File: tb/tb_ship_life_ctl.sv
// Table-driven bench for ship_life_ctl with default parameters (LIVES=3, 60/120/8 frames).
module tb_ship_life_ctl;

  logic       pclk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       hit = 1'b0;
  logic       vsync_in = 1'b0;
`ifdef SHIP_EXTRA_LIFE_EN
  logic       extra_life = 1'b0;
`endif
  logic       ship_dead, ship_visible, fire_enable, respawn, game_over;
  logic [3:0] dead_count, lives_left;
  logic [2:0] state_out;

  int n_cmp = 0;
  int n_bad = 0;
  int resp_seen = 0;

  typedef struct {
    logic start; logic hit; logic xl; int ticks;
    int st; int dead; int vis; int fire; int go; int dc; int ll; int resp;
  } vec_t;

  vec_t vq[$];
  vec_t xq[$];

  always #5 pclk = ~pclk;

  ship_life_ctl dut (
    .pclk         (pclk),
    .rst          (rst),
    .start        (start),
    .hit          (hit),
    .vsync_in     (vsync_in),
`ifdef SHIP_EXTRA_LIFE_EN
    .extra_life   (extra_life),
`endif
    .ship_dead    (ship_dead),
    .ship_visible (ship_visible),
    .fire_enable  (fire_enable),
    .respawn      (respawn),
    .dead_count   (dead_count),
    .lives_left   (lives_left),
    .game_over    (game_over),
    .state_out    (state_out)
  );

  always @(negedge pclk) begin
    if (respawn) resp_seen++;
  end

  task automatic chk(input string nm, input int idx, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %0d expected %0d", nm, idx, act, exp);
    end
  endtask

  // One vsync pulse; returns on a negedge after the resulting tick has been consumed.
  task automatic vsync_pulse();
    vsync_in = 1'b1;
    repeat (2) @(negedge pclk);
    vsync_in = 1'b0;
    repeat (4) @(negedge pclk);
  endtask

  task automatic chk_all(input int idx, input vec_t v);
    chk("state", idx, int'(state_out), v.st);
    chk("ship_dead", idx, int'(ship_dead), v.dead);
    chk("ship_visible", idx, int'(ship_visible), v.vis);
    chk("fire_enable", idx, int'(fire_enable), v.fire);
    chk("game_over", idx, int'(game_over), v.go);
    chk("dead_count", idx, int'(dead_count), v.dc);
    chk("lives_left", idx, int'(lives_left), v.ll);
    chk("respawn_pulses", idx, resp_seen, v.resp);
  endtask

  task automatic run_row(input int idx, input vec_t v);
    start = v.start;
    hit   = v.hit;
`ifdef SHIP_EXTRA_LIFE_EN
    extra_life = v.xl;
`endif
    @(negedge pclk);
    hit = 1'b0;
`ifdef SHIP_EXTRA_LIFE_EN
    extra_life = 1'b0;
`endif
    repeat (v.ticks) vsync_pulse();
    @(negedge pclk);
    chk_all(idx, v);
  endtask

  initial begin
    //              start hit  xl   ticks st dead vis fire go dc ll resp
    vq.push_back('{1'b1, 1'b0, 1'b0, 0,   3, 0,   1,  1,   0, 0, 3, 1});
    vq.push_back('{1'b1, 1'b0, 1'b0, 7,   3, 0,   1,  1,   0, 0, 3, 1});
    vq.push_back('{1'b1, 1'b0, 1'b0, 1,   3, 0,   0,  1,   0, 0, 3, 1});
    vq.push_back('{1'b1, 1'b0, 1'b0, 8,   3, 0,   1,  1,   0, 0, 3, 1});
    vq.push_back('{1'b1, 1'b0, 1'b0, 8,   3, 0,   0,  1,   0, 0, 3, 1});
    vq.push_back('{1'b1, 1'b0, 1'b0, 95,  3, 0,   1,  1,   0, 0, 3, 1});
    vq.push_back('{1'b1, 1'b1, 1'b0, 0,   3, 0,   1,  1,   0, 0, 3, 1});
    vq.push_back('{1'b1, 1'b0, 1'b0, 1,   1, 0,   1,  1,   0, 0, 3, 1});
    vq.push_back('{1'b1, 1'b1, 1'b0, 0,   2, 1,   0,  0,   0, 1, 2, 1});
    vq.push_back('{1'b1, 1'b1, 1'b0, 30,  2, 1,   0,  0,   0, 1, 2, 1});
    vq.push_back('{1'b1, 1'b0, 1'b0, 29,  2, 1,   0,  0,   0, 1, 2, 1});
    vq.push_back('{1'b1, 1'b0, 1'b0, 1,   3, 0,   1,  1,   0, 1, 2, 2});
    vq.push_back('{1'b1, 1'b0, 1'b0, 120, 1, 0,   1,  1,   0, 1, 2, 2});
    vq.push_back('{1'b1, 1'b1, 1'b0, 0,   2, 1,   0,  0,   0, 2, 1, 2});
    vq.push_back('{1'b1, 1'b0, 1'b0, 60,  3, 0,   1,  1,   0, 2, 1, 3});
    vq.push_back('{1'b1, 1'b0, 1'b0, 120, 1, 0,   1,  1,   0, 2, 1, 3});
    vq.push_back('{1'b1, 1'b1, 1'b0, 0,   4, 1,   0,  0,   1, 3, 0, 3});
    vq.push_back('{1'b1, 1'b0, 1'b0, 5,   4, 1,   0,  0,   1, 3, 0, 3});
    vq.push_back('{1'b0, 1'b0, 1'b0, 0,   4, 1,   0,  0,   1, 3, 0, 3});
    vq.push_back('{1'b1, 1'b0, 1'b0, 0,   3, 0,   1,  1,   0, 0, 3, 4});

    xq.push_back('{1'b1, 1'b0, 1'b0, 0,   3, 0,   1,  1,   0, 0, 3, 5});
    xq.push_back('{1'b1, 1'b0, 1'b0, 120, 1, 0,   1,  1,   0, 0, 3, 5});
    xq.push_back('{1'b1, 1'b1, 1'b0, 0,   2, 1,   0,  0,   0, 1, 2, 5});
    xq.push_back('{1'b1, 1'b0, 1'b0, 60,  3, 0,   1,  1,   0, 1, 2, 6});
    xq.push_back('{1'b1, 1'b0, 1'b0, 120, 1, 0,   1,  1,   0, 1, 2, 6});
    xq.push_back('{1'b1, 1'b1, 1'b0, 0,   2, 1,   0,  0,   0, 2, 1, 6});
    xq.push_back('{1'b1, 1'b0, 1'b1, 0,   2, 1,   0,  0,   0, 1, 2, 6});
    xq.push_back('{1'b1, 1'b0, 1'b0, 60,  3, 0,   1,  1,   0, 1, 2, 7});
    xq.push_back('{1'b1, 1'b0, 1'b0, 120, 1, 0,   1,  1,   0, 1, 2, 7});
    xq.push_back('{1'b1, 1'b1, 1'b1, 0,   2, 1,   0,  0,   0, 1, 2, 7});

    repeat (2) @(negedge pclk);
    chk_all(100, '{1'b0, 1'b0, 1'b0, 0, 0, 1, 0, 0, 0, 0, 3, 0});
    rst = 1'b1;
    repeat (2) @(negedge pclk);
    chk("idle_hold", 101, int'(state_out), 0);

    foreach (vq[i]) run_row(i, vq[i]);

    // Reach DYING with frame_cnt=30, then pull reset asynchronously between edges.
    repeat (120) vsync_pulse();
    @(negedge pclk);
    chk("pre_hit_state", 200, int'(state_out), 1);
    hit = 1'b1;
    @(negedge pclk);
    hit = 1'b0;
    repeat (30) vsync_pulse();
    chk("dying_state", 201, int'(state_out), 2);
    chk("dying_count", 201, int'(dead_count), 1);
    #2 rst = 1'b0;
    #1;
    chk_all(202, '{1'b0, 1'b0, 1'b0, 0, 0, 1, 0, 0, 0, 0, 3, 4});
    chk("respawn_level", 202, int'(respawn), 0);
    start = 1'b0;
    repeat (3) @(negedge pclk);
    rst = 1'b1;
    repeat (3) @(negedge pclk);
    chk_all(203, '{1'b0, 1'b0, 1'b0, 0, 0, 1, 0, 0, 0, 0, 3, 4});

`ifdef SHIP_EXTRA_LIFE_EN
    foreach (xq[i]) run_row(300 + i, xq[i]);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ship_life_ctl.md
Name: ship_life_ctl

Overview:
Sequences the player ship's life cycle: ALIVE, death freeze, respawn with blinking invulnerability, and game over. Consumes the collision hit pulse and the frame timing. Drives the ship-dead lock, position respawn, missile fire gating, ship visibility and the lives/death count that feed the lives display.
Sits beside the ship draw chain, per player instance. It replaces the ad-hoc latch/counter/unlock trio.

Parameters:
LIVES, 3, lives granted at game start (1..15)
DEATH_FRAMES, 60, frames the ship stays frozen/hidden after a hit
INVULN_FRAMES, 120, frames of post-respawn invulnerability (>=1)
BLINK_FRAMES, 8, half-period of the invulnerability blink, in frames (>=1)

Ports:
pclk  in  1  pixel clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  level; game start/restart request
hit  in  1  one-cycle pulse from collision detector
vsync_in  in  1  raw vsync from timing chain
ship_dead  out  1  high = freeze movement, suppress missile, hide ship
ship_visible  out  1  ship sprite enable (blinks during invulnerability)
fire_enable  out  1  missile controller may launch
respawn  out  1  one-cycle pulse: reload ship X to reset position
dead_count  out  4  deaths so far, 0..LIVES, for heart display
lives_left  out  4  LIVES - dead_count
game_over  out  1  high in GAME_OVER
state_out  out  3  current FSM state encoding (debug)

Behaviour:
- Reset (rst=0, async): state IDLE, all counters 0. Outputs: ship_dead=1, ship_visible=0, fire_enable=0, respawn=0, dead_count=0, lives_left=LIVES, game_over=0.
- frame_tick: one-cycle pulse, registered. It asserts on the pclk cycle after a 0->1 edge of vsync_in is sampled. vsync_in passes through two sync flops first, so tick latency is 3 pclk from the edge.
- frame_cnt is 8 bits. It clears on every state entry and increments on frame_tick, saturating at 255.
- IDLE: start=1 -> RESPAWN. On this transition, respawn pulses and dead_count clears.
- ALIVE: ship_dead=0, ship_visible=1, fire_enable=1.
  - hit=1 -> DYING and dead_count+1 in the same cycle.
  - If the new dead_count == LIVES, the next state is GAME_OVER instead.
- DYING: ship_dead=1, ship_visible=0, fire_enable=0. hit is ignored.
  - When frame_cnt reaches DEATH_FRAMES -> RESPAWN, with a respawn pulse on the transition cycle.
- RESPAWN (invulnerable): ship_dead=0, fire_enable=1, hit ignored.
  - ship_visible = ~frame_cnt/BLINK_FRAMES parity: visible for the first BLINK_FRAMES frames, then toggles every BLINK_FRAMES frames.
  - When frame_cnt reaches INVULN_FRAMES -> ALIVE.
- GAME_OVER: ship_dead=1, ship_visible=0, fire_enable=0, game_over=1.
  - start must be seen low, then high (rising edge), to go to RESPAWN with dead_count=0 and a respawn pulse. A start held high from before does not restart.
- Each hit decrements lives by at most one. lives_left is purely combinational from dead_count and never underflows.
- hit arriving in the same cycle as frame_tick in ALIVE: hit wins.
- Entry to RESPAWN from IDLE/GAME_OVER also requires the start rising-edge rule.
- Reset mid-operation returns to IDLE immediately. No respawn pulse is issued from reset.
- All outputs are registered except lives_left and state_out.

Optional Feature:
SHIP_EXTRA_LIFE_EN:
- Defined: adds input extra_life (1-cycle pulse, e.g. score milestone). In any non-GAME_OVER state, it decrements dead_count if dead_count>0; otherwise it is ignored.
- If it coincides with an accepted hit, the two cancel: the FSM still goes to DYING, but dead_count is unchanged.
- Undefined: the port is absent and dead_count is monotonic until restart.

Decomposition:
- Package ship_ctl_pkg holds:
  - state encoding constants: IDLE=0, ALIVE=1, DYING=2, RESPAWN=3, GAME_OVER=4
  - the frame counter width (8)
  - the count width (4)
- One sub-module, frame_tick_gen: vsync synchroniser plus rising-edge pulse. It is reusable by enemy and missile controllers.

Test Plan:
- Reset, then start=1 -> respawn pulse once. Next: ship_visible toggles every 8 frames, ALIVE reached after 120 ticks, fire_enable=1 throughout.
- In ALIVE, hit pulse -> next cycle ship_dead=1, dead_count=1, lives_left=2. After 60 ticks: respawn pulse, RESPAWN.
- hit pulses during DYING and RESPAWN -> dead_count unchanged, state unchanged.
- Three hits, each separated by a full respawn -> after the third: game_over=1, dead_count=3, lives_left=0.
  - start held high -> stays in GAME_OVER.
  - start low then high -> RESPAWN, dead_count=0.
- rst asserted low mid-DYING (frame_cnt=30) -> async IDLE, dead_count=0, ship_dead=1, no respawn pulse.
- SHIP_EXTRA_LIFE_EN: dead_count=2, extra_life -> 1. Then hit+extra_life in the same cycle -> DYING, dead_count stays 1.
